maxpool_controller: RTL and testbench
=====================================

# maxpool_controller

Streaming 2x2/stride-2 max-pool sequencer around the existing `comparator`. It accepts a raster-order feature-map stream over a valid/ready handshake and buffers each even row in a line buffer. On each odd row it presents 2x2 windows to the comparator and emits the pooled stream over a second valid/ready handshake. It sits between a convolution/activation stage and the next layer's input buffer.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH` from `cnn_defs`: pixel width, unsigned.
- `MAX_WIDTH`, default 64: maximum feature-map width; sets line-buffer depth. Must be even, ≥2.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- `cfg_width`  in  $clog2(MAX_WIDTH)+1  frame width in pixels; latched on accepted `start`.
- `cfg_height`  in  16  frame height in rows; latched on accepted `start`.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  controller can accept a pixel.
- `in_data`  in  DATA_WIDTH  input pixel.
- `out_valid`  out  1  pooled result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  DATA_WIDTH  pooled result.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last pooled result is accepted.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected for bad config.

## Operation
- The input transfer is `in_valid && in_ready`. The output transfer is `out_valid && out_ready`.
- FSM states: IDLE, ROW_EVEN, ROW_ODD, DRAIN.
- **IDLE:** `in_ready`=0.
  - `start` with `cfg_width` even, in 2..MAX_WIDTH, and `cfg_height` even and ≥2: latch config, clear `col`/`row`, go to ROW_EVEN, and set `busy`.
  - `start` with any other config: pulse `cfg_err` next cycle and stay in IDLE.
- **ROW_EVEN:** `in_ready`=1.
  - Each transfer writes `line_buf[col]` and increments `col`.
  - At `col==cfg_width-1`: clear `col`, increment `row`, go to ROW_ODD.
- **ROW_ODD:**
  - Even `col`: `in_ready`=1 and the pixel is stored in `hold`.
  - Odd `col`: `in_ready` = `!out_valid || out_ready`.
  - An odd-column transfer loads the output register with `comparator(line_buf[col-1], line_buf[col], hold, in_data)`.
  - At end of row: if `row==cfg_height-1`, go to DRAIN; otherwise clear `col`, increment `row`, go to ROW_EVEN.
- **DRAIN:** `in_ready`=0. When the final result transfers, pulse `done`, clear `busy`, go to IDLE.
- `out_valid` is set on load and cleared on an output transfer with no same-cycle load. A simultaneous load and transfer keeps `out_valid`=1 with the new data.
- `start` outside IDLE is ignored; no `cfg_err`.
- `out_data` holds its value while `out_valid && !out_ready`.
- Ties and equal values are resolved by the comparator; the result is the value regardless of which input supplied it.

## Timing
- Reset (async assert, any state): FSM→IDLE, counters 0; `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `cfg_err`=0. Line-buffer contents are don't-care.
- Mid-frame reset discards the partial frame; no `done`.
- `busy` rises the cycle after the accepted `start`. ROW_EVEN `in_ready` is high that same cycle.
- Latency: `out_valid` rises one cycle after the 4th pixel of a window transfers.
- Throughput: one pixel per cycle with `out_ready` held high.
- Backpressure: stalls only odd-column pixels of odd rows. Even-row and even-column pixels are never stalled.
- `done` is asserted in the same cycle as the final output transfer's effect, i.e. the cycle after the final handshake.
- Counters are sized to `cfg_width`/`cfg_height` ranges, so no wrap-around occurs within a frame.

## Structure
- `cnn_defs` package holds `DATA_WIDTH` and the `pool_state_t` enum (IDLE, ROW_EVEN, ROW_ODD, DRAIN).
- One sub-module: the existing `comparator`, instantiated once with `DATA_WIDTH`.
- The line buffer is a local `MAX_WIDTH`×`DATA_WIDTH` register array with synchronous write and combinational read of `col-1`/`col`. No separate RAM module.

## Test plan
- **4x4 basic:** 4x4 frame, pixels 0..15 raster order, `out_ready`=1 → outputs 5, 7, 13, 15 in order; `done` one pulse; `busy` low after.
- **Backpressure:** same frame, `out_ready` toggling 1-of-3 cycles → identical outputs with no loss or duplication; `in_ready` low only at odd-column pixels of odd rows while the output is held; `out_data` stable while stalled.
- **Bad config:** `start` with `cfg_width`=3, then `cfg_height`=0, then `cfg_width`=MAX_WIDTH+2 → three `cfg_err` pulses, `busy` stays 0, `in_ready` stays 0.
- **Start while busy:** `start` asserted mid-frame with different config → ignored; frame completes with the original config's output count.
- **Reset mid-frame:** assert `rst_n`=0 during ROW_ODD with `out_valid`=1 → all outputs at reset values; then run a 2x2 frame {9, 200, 3, 255} → single output 255.
- **Max width, extreme values:** 64x2 frame, all 0xFF except 0x00 in column 0 → 32 outputs, all 0xFF. Then an all-0x00 frame → 32 outputs of 0x00.

Source files
------------

// File: rtl/cnn_defs.sv
// rtl/cnn_defs.sv - shared CNN datapath width and max-pool sequencer states
package cnn_defs;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      ROW_EVEN,
      ROW_ODD,
      DRAIN
   } pool_state_t;

endpackage

// File: rtl/comparator.sv
// rtl/comparator.sv - unsigned maximum of a 2x2 pooling window
module comparator #(
   parameter int DATA_WIDTH = cnn_defs::DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] c,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] max_out
);

   logic [DATA_WIDTH-1:0] max_ab;
   logic [DATA_WIDTH-1:0] max_cd;

   assign max_ab  = (a >= b) ? a : b;
   assign max_cd  = (c >= d) ? c : d;
   assign max_out = (max_ab >= max_cd) ? max_ab : max_cd;

endmodule

// File: rtl/maxpool_controller.sv
// rtl/maxpool_controller.sv - streaming 2x2/stride-2 max-pool sequencer with line buffer
module maxpool_controller #(
   parameter int DATA_WIDTH = cnn_defs::DATA_WIDTH,
   parameter int MAX_WIDTH  = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [$clog2(MAX_WIDTH):0]  cfg_width,
   input  logic [15:0]                 cfg_height,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        busy,
   output logic                        done,
   output logic                        cfg_err
);

   import cnn_defs::*;

   localparam int CW = $clog2(MAX_WIDTH) + 1;
   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   pool_state_t           state, state_next;
   logic [CW-1:0]         width_q;
   logic [15:0]           height_q;
   logic [CW-1:0]         col;
   logic [15:0]           row;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] line_buf [MAX_WIDTH];
   logic [DATA_WIDTH-1:0] pool_max;
   logic [AW-1:0]         cur_idx, prev_idx;
   logic                  cfg_ok, last_col, last_row;
   logic                  in_xfer, out_xfer, load;

   assign cfg_ok = !cfg_width[0] && (cfg_width >= CW'(2)) && (cfg_width <= CW'(MAX_WIDTH)) &&
                   !cfg_height[0] && (cfg_height >= 16'd2);

   assign last_col = (col == width_q - CW'(1));
   assign last_row = (row == height_q - 16'd1);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign load     = (state == ROW_ODD) && col[0] && in_xfer;
   assign cur_idx  = col[AW-1:0];
   assign prev_idx = cur_idx - AW'(1);

   comparator #(.DATA_WIDTH(DATA_WIDTH)) u_comparator (
      .a       (line_buf[prev_idx]),
      .b       (line_buf[cur_idx]),
      .c       (hold),
      .d       (in_data),
      .max_out (pool_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Only the window-completing pixel of an odd row waits on the output register.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            if (start && cfg_ok) state_next = ROW_EVEN;
         end
         ROW_EVEN: begin
            in_ready = 1'b1;
            if (in_valid && last_col) state_next = ROW_ODD;
         end
         ROW_ODD: begin
            in_ready = col[0] ? (!out_valid || out_ready) : 1'b1;
            if (in_valid && in_ready && last_col) state_next = last_row ? DRAIN : ROW_EVEN;
         end
         DRAIN: begin
            if (out_valid && out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q   <= '0;
         height_q  <= '0;
         col       <= '0;
         row       <= '0;
         hold      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     width_q  <= cfg_width;
                     height_q <= cfg_height;
                     col      <= '0;
                     row      <= '0;
                     busy     <= 1'b1;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ROW_EVEN: begin
               if (in_xfer) begin
                  if (last_col) begin
                     col <= '0;
                     row <= row + 16'd1;
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            ROW_ODD: begin
               if (in_xfer) begin
                  if (!col[0]) hold <= in_data;
                  if (last_col) begin
                     col <= '0;
                     if (!last_row) row <= row + 16'd1;
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_xfer) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: ;
         endcase
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= pool_max;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Contents are don't-care after reset, so the buffer carries no reset.
   always_ff @(posedge clk) begin
      if (state == ROW_EVEN && in_xfer) line_buf[cur_idx] <= in_data;
   end

endmodule

// File: tb/tb_maxpool_controller.sv
// tb/tb_maxpool_controller.sv - directed self-checking bench for maxpool_controller
module tb_maxpool_controller;

   localparam int DW = cnn_defs::DATA_WIDTH;
   localparam int MW = 64;
   localparam int CW = $clog2(MW) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_width = '0;
   logic [15:0]   cfg_height = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          busy, done, cfg_err;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] pix_mem [256];
   logic [DW-1:0] out_q [$];
   int done_cnt = 0, cfg_err_cnt = 0, stall_cnt = 0, bad_stall_cnt = 0, hold_err_cnt = 0;
   int bp_mode = 0;
   int cyc = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   maxpool_controller #(.DATA_WIDTH(DW), .MAX_WIDTH(MW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      case (bp_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 3 == 0);
         default: out_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) out_q.push_back(out_data);
         if (done) done_cnt = done_cnt + 1;
         if (cfg_err) cfg_err_cnt = cfg_err_cnt + 1;
         if (in_valid && busy && !in_ready) begin
            if (out_valid && !out_ready) stall_cnt = stall_cnt + 1;
            else bad_stall_cnt = bad_stall_cnt + 1;
         end
         if (prev_hold && (!out_valid || out_data !== prev_data)) hold_err_cnt = hold_err_cnt + 1;
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic clear_stats();
      out_q.delete();
      done_cnt = 0; cfg_err_cnt = 0; stall_cnt = 0; bad_stall_cnt = 0; hold_err_cnt = 0;
   endtask

   task automatic do_start(input int w, input int h);
      start = 1'b1;
      cfg_width = CW'(w);
      cfg_height = 16'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_frame(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         int guard = 0;
         in_valid = 1'b1;
         in_data = pix_mem[i];
         @(negedge clk);
         while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
         end
         if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout pixel %0d got stuck low", i);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int g = 0;
      while (done_cnt < target && g < 1000) begin
         @(negedge clk);
         g++;
      end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL done_timeout got %0d pulses exp %0d", done_cnt, target);
      end
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_data, busy, done, cfg_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 0", {in_ready, out_valid, out_data, busy, done, cfg_err});
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got in_ready=%b busy=%b out_valid=%b exp 0", in_ready, busy, out_valid);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp_v [4];
      exp_v = '{DW'(5), DW'(7), DW'(13), DW'(15)};
      bp_mode = 0;
      clear_stats();
      for (int i = 0; i < 16; i++) pix_mem[i] = DW'(i);
      do_start(4, 4);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_rise got busy=%b in_ready=%b exp 1 1", busy, in_ready);
      end
      send_frame(0, 16);
      wait_done(1);
      checks++;
      if (out_q.size() !== 4) begin
         errors++;
         $display("FAIL basic_count got %0d exp 4", out_q.size());
      end
      for (int i = 0; i < 4 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_v[i]) begin
            errors++;
            $display("FAIL basic_out%0d got %0d exp %0d", i, out_q[i], exp_v[i]);
         end
      end
      checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done got done_cnt=%0d busy=%b exp 1 0", done_cnt, busy);
      end
      checks++;
      if (stall_cnt !== 0 || bad_stall_cnt !== 0) begin
         errors++;
         $display("FAIL basic_throughput got stalls=%0d bad=%0d exp 0 0", stall_cnt, bad_stall_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] exp_v [4];
      int total_stalls = 0;
      exp_v = '{DW'(5), DW'(7), DW'(13), DW'(15)};
      for (int ph = 0; ph < 3; ph++) begin
         bp_mode = 1;
         clear_stats();
         for (int i = 0; i < 16; i++) pix_mem[i] = DW'(i);
         cyc = ph;
         do_start(4, 4);
         send_frame(0, 16);
         wait_done(1);
         total_stalls += stall_cnt;
         checks++;
         if (out_q.size() !== 4) begin
            errors++;
            $display("FAIL bp_count phase %0d got %0d exp 4", ph, out_q.size());
         end
         for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_v[i]) begin
               errors++;
               $display("FAIL bp_out%0d phase %0d got %0d exp %0d", i, ph, out_q[i], exp_v[i]);
            end
         end
         checks++;
         if (bad_stall_cnt !== 0 || hold_err_cnt !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL bp_rules phase %0d got bad_stall=%0d hold_err=%0d done=%0d exp 0 0 1",
                     ph, bad_stall_cnt, hold_err_cnt, done_cnt);
         end
      end
      checks++;
      if (total_stalls == 0) begin
         errors++;
         $display("FAIL bp_stall_seen got 0 stalls exp >0");
      end
      bp_mode = 0;
   endtask

   task automatic test_bad_config();
      int bw [3];
      int bh [3];
      bw = '{3, 4, MW + 2};
      bh = '{4, 0, 4};
      bp_mode = 0;
      clear_stats();
      for (int k = 0; k < 3; k++) begin
         do_start(bw[k], bh[k]);
         checks++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_cfg%0d got cfg_err=%b busy=%b in_ready=%b exp 1 0 0", k, cfg_err, busy, in_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_cfg%0d_pulse got cfg_err=%b busy=%b exp 0 0", k, cfg_err, busy);
         end
      end
      checks++;
      if (cfg_err_cnt !== 3) begin
         errors++;
         $display("FAIL bad_cfg_count got %0d exp 3", cfg_err_cnt);
      end
   endtask

   task automatic test_start_busy();
      logic [DW-1:0] exp_v [4];
      exp_v = '{DW'(5), DW'(7), DW'(13), DW'(15)};
      bp_mode = 0;
      clear_stats();
      for (int i = 0; i < 16; i++) pix_mem[i] = DW'(i);
      do_start(4, 4);
      fork
         send_frame(0, 16);
         begin
            repeat (6) @(posedge clk);
            #1;
            start = 1'b1; cfg_width = CW'(2); cfg_height = 16'd2;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      wait_done(1);
      checks++;
      if (out_q.size() !== 4 || cfg_err_cnt !== 0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL start_busy got outputs=%0d cfg_err=%0d done=%0d exp 4 0 1", out_q.size(), cfg_err_cnt, done_cnt);
      end
      for (int i = 0; i < 4 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_v[i]) begin
            errors++;
            $display("FAIL start_busy_out%0d got %0d exp %0d", i, out_q[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bp_mode = 2;
      clear_stats();
      for (int i = 0; i < 16; i++) pix_mem[i] = DW'(i);
      do_start(4, 4);
      send_frame(0, 5);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_pre got out_valid=%b exp 0", out_valid);
      end
      send_frame(5, 6);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(5)) begin
         errors++;
         $display("FAIL latency_post got out_valid=%b data=%0d exp 1 5", out_valid, out_data);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_data, busy, done, cfg_err} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got %b exp 0", {in_ready, out_valid, out_data, busy, done, cfg_err});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_nodone got done=%0d busy=%b exp 0 0", done_cnt, busy);
      end
      bp_mode = 0;
      clear_stats();
      pix_mem[0] = DW'(9); pix_mem[1] = DW'(200); pix_mem[2] = DW'(3); pix_mem[3] = DW'(255);
      do_start(2, 2);
      send_frame(0, 4);
      wait_done(1);
      checks++;
      if (out_q.size() !== 1) begin
         errors++;
         $display("FAIL frame2x2_count got %0d exp 1", out_q.size());
      end else begin
         checks++;
         if (out_q[0] !== DW'(255)) begin
            errors++;
            $display("FAIL frame2x2_out got %0d exp 255", out_q[0]);
         end
      end
   endtask

   task automatic test_max_width();
      for (int pass = 0; pass < 2; pass++) begin
         logic [DW-1:0] expv;
         expv = (pass == 0) ? '1 : '0;
         bp_mode = 0;
         clear_stats();
         for (int i = 0; i < 2 * MW; i++) pix_mem[i] = (pass == 0 && (i % MW) != 0) ? '1 : '0;
         do_start(MW, 2);
         send_frame(0, 2 * MW);
         wait_done(1);
         checks++;
         if (out_q.size() !== MW / 2) begin
            errors++;
            $display("FAIL maxw%0d_count got %0d exp %0d", pass, out_q.size(), MW / 2);
         end
         for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== expv) begin
               errors++;
               $display("FAIL maxw%0d_out%0d got %0h exp %0h", pass, i, out_q[i], expv);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_bad_config();
      test_start_busy();
      test_reset_mid();
      test_max_width();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
